median3_stream: RTL and testbench

Streaming 3-tap order-statistic filter for unsigned WIDTH-bit samples with valid/ready handshakes on both sides. It keeps a sliding window of the last three accepted samples. For every accepted sample once the window is full, it emits one registered result: median, min, max or centre tap, selected per sample. It sits in the data path after the sample source and before downstream consumers that need impulse-noise rejection. It generalises the single-bit median selector to a parametrised, clocked, back-pressured block.

---
 rtl/median3_stream.sv | 122 ++++++++++++
 tb/tb_median3_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/median3_stream.sv
// Streaming 3-tap order-statistic filter (median/min/max/centre) with
// valid/ready handshakes on both sides and a registered result.
module median3_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             primed
);

  typedef enum logic [1:0] {
    MODE_MED = 2'b00,
    MODE_MIN = 2'b01,
    MODE_MAX = 2'b10,
    MODE_CTR = 2'b11
  } mode_t;

  logic [1:0]       fill_reg, fill_next;
  logic [WIDTH-1:0] w1_reg, w1_next;
  logic [WIDTH-1:0] w2_reg, w2_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             primed_reg, primed_next;

  logic             full;
  logic             accept;
  logic             a_ge_b, b_ge_c, a_ge_c;
  logic [WIDTH-1:0] med_val, min_val, max_val, result;

  assign full     = (fill_reg == 2'd2);
  // Warm-up never blocks: no result is produced, so the output register is irrelevant.
  assign in_ready = !flush && (!full || !out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // a = incoming sample, b = w1, c = w2
  assign a_ge_b = (in_data >= w1_reg);
  assign b_ge_c = (w1_reg  >= w2_reg);
  assign a_ge_c = (in_data >= w2_reg);

  always_comb begin
    if (a_ge_b) begin
      med_val = b_ge_c ? w1_reg : (a_ge_c ? w2_reg : in_data);
      min_val = b_ge_c ? w2_reg : w1_reg;
      max_val = a_ge_c ? in_data : w2_reg;
    end else begin
      med_val = a_ge_c ? in_data : (b_ge_c ? w2_reg : w1_reg);
      min_val = a_ge_c ? w2_reg : in_data;
      max_val = b_ge_c ? w1_reg : w2_reg;
    end
  end

  always_comb begin
    case (mode_t'(mode))
      MODE_MED: result = med_val;
      MODE_MIN: result = min_val;
      MODE_MAX: result = max_val;
      default:  result = w1_reg;
    endcase
  end

  always_comb begin
    fill_next      = fill_reg;
    w1_next        = w1_reg;
    w2_next        = w2_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;

    // flush and accept are exclusive because in_ready is low during flush
    if (flush) begin
      fill_next = 2'd0;
      w1_next   = '0;
      w2_next   = '0;
    end else if (accept) begin
      w2_next = w1_reg;
      w1_next = in_data;
      if (full) begin
        out_data_next = result;
      end else begin
        fill_next = fill_reg + 2'd1;
      end
    end

    if (accept && full) begin
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end

    primed_next = (fill_next == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_reg      <= 2'd0;
      w1_reg        <= '0;
      w2_reg        <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      primed_reg    <= 1'b0;
    end else begin
      fill_reg      <= fill_next;
      w1_reg        <= w1_next;
      w2_reg        <= w2_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      primed_reg    <= primed_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign primed    = primed_reg;

endmodule

// File: tb/tb_median3_stream.sv
// Self-checking bench for median3_stream: directed scenarios plus a randomised
// stream compared against a sort-based reference model.
module tb_median3_stream;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, primed;
  logic [7:0] in_data, out_data;
  logic [1:0] mode;

  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_primed;
  logic [11:0] c_in_data, c_out_data;
  logic [1:0]  c_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  median3_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .primed(primed)
  );

  median3_stream #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .mode(c_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .primed(c_primed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(input int v, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = 8'(v); mode = m;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 50) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick;
    in_valid = 1'b0;
    $display("send data=%0d mode=%0d -> out_valid=%0d out_data=%0d primed=%0d",
             v, m, out_valid, out_data, primed);
  endtask

  // Reference: sort the three taps and pick by mode; centre is the previous sample.
  function automatic int ref_f(input logic [1:0] m, input int a, input int b, input int c);
    int s[3];
    int t;
    s[0] = a; s[1] = b; s[2] = c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    case (m)
      2'b00:   return s[1];
      2'b01:   return s[0];
      2'b10:   return s[2];
      default: return b;
    endcase
  endfunction

  initial begin
    int w12[3];
    int mw1, mw2, md, mfill, acc_n, res_n, cons_n, cyc;
    bit mv, mrdy, macc;

    in_data = '0; mode = '0; out_ready = 1'b1;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_mode = 2'b00; c_out_ready = 1'b1;
    do_reset;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_primed",    primed,    0);
    chk("rst_in_ready",  in_ready,  1);

    // Basic median stream
    send(10, 2'b00);  chk("t1_v1", out_valid, 0);
    send(200, 2'b00); chk("t1_v2", out_valid, 0); chk("t1_primed", primed, 1);
    send(30, 2'b00);  chk("t1_v3", out_valid, 1); chk("t1_d3", out_data, 30);
    send(40, 2'b00);  chk("t1_d4", out_data, 40);
    send(40, 2'b00);  chk("t1_d5", out_data, 40);

    // Mode switching
    do_reset;
    send(7, 2'b00); send(3, 2'b00);
    send(9, 2'b00); chk("t2_med", out_data, 7);
    send(1, 2'b01); chk("t2_min", out_data, 1);
    send(4, 2'b10); chk("t2_max", out_data, 9);
    send(2, 2'b11); chk("t2_ctr", out_data, 4);
    send(2, 2'b00); chk("t2_med2", out_data, 2); chk("t2_valid", out_valid, 1);

    // Back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd50; mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, 2);
      chk("bp_hold_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_new_valid", out_valid, 1);
    chk("bp_new_data", out_data, 50);
    tick;
    chk("bp_drained", out_valid, 0);

    // Flush with a pending result
    do_reset;
    send(10, 2'b00); send(20, 2'b00); send(30, 2'b00);
    send(40, 2'b00);
    out_ready = 1'b0;
    chk("fl_pending", out_data, 30);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick;
    flush = 1'b0;
    chk("fl_primed", primed, 0);
    chk("fl_keep_valid", out_valid, 1);
    chk("fl_keep_data", out_data, 30);
    send(100, 2'b00); chk("fl_a1_data", out_data, 30); chk("fl_a1_primed", primed, 0);
    send(5, 2'b00);   chk("fl_a2_data", out_data, 30); chk("fl_a2_primed", primed, 1);
    out_ready = 1'b1;
    tick;
    chk("fl_taken", out_valid, 0);
    send(7, 2'b00); chk("fl_a3_valid", out_valid, 1); chk("fl_a3_data", out_data, 7);

    // Reset mid-stream, with flush asserted alongside
    do_reset;
    out_ready = 1'b0;
    send(1, 2'b00); send(2, 2'b00); send(3, 2'b00);
    chk("rs_pre_valid", out_valid, 1);
    rst_n = 1'b0; flush = 1'b1;
    tick;
    rst_n = 1'b1; flush = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_data", out_data, 0);
    chk("rs_primed", primed, 0);
    out_ready = 1'b1;
    send(8, 2'b00); chk("rs_a1", out_valid, 0);
    send(9, 2'b00); chk("rs_a2", out_valid, 0); chk("rs_a2_primed", primed, 1);
    send(4, 2'b00); chk("rs_a3_valid", out_valid, 1); chk("rs_a3_data", out_data, 8);

    // WIDTH=12 median
    w12[0] = 4095; w12[1] = 0; w12[2] = 2048;
    for (int i = 0; i < 3; i++) begin
      c_in_valid = 1'b1; c_in_data = 12'(w12[i]);
      tick;
    end
    c_in_valid = 1'b0;
    chk("w12_valid", c_out_valid, 1);
    chk("w12_data", c_out_data, 2048);
    $display("w12 median -> %0d", c_out_data);

    // Randomised stream against the reference model
    do_reset;
    mw1 = 0; mw2 = 0; md = 0; mfill = 0; mv = 1'b0;
    acc_n = 0; res_n = 0; cons_n = 0; cyc = 0;
    while (acc_n < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      mrdy = !flush && (mfill < 2 || !mv || out_ready);
      chk("rnd_in_ready", in_ready, mrdy);
      macc = in_valid && mrdy;
      if (out_valid && out_ready) cons_n++;
      if (macc && mfill == 2) begin
        md = ref_f(mode, int'(in_data), mw1, mw2);
        mv = 1'b1;
        res_n++;
        $display("rnd result #%0d mode=%0d taps=(%0d,%0d,%0d) expect=%0d",
                 res_n, mode, in_data, mw1, mw2, md);
      end else if (out_ready) begin
        mv = 1'b0;
      end
      if (flush) begin
        mfill = 0; mw1 = 0; mw2 = 0;
      end else if (macc) begin
        mw2 = mw1; mw1 = int'(in_data);
        if (mfill < 2) mfill++;
        acc_n++;
      end
      tick;
      cyc++;
      chk("rnd_out_valid", out_valid, mv);
      if (mv) chk("rnd_out_data", out_data, md);
      chk("rnd_primed", primed, (mfill == 2));
    end
    chk("rnd_budget", acc_n, 1000);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid) cons_n++;
    tick;
    chk("rnd_drained", out_valid, 0);
    chk("rnd_count", cons_n, res_n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
